// File: rtl/transmit_delay_scheduler_pkg.sv
// Shared widths, fixed-point types and FSM encoding for the transmit delay scheduler.
// Delay/error widths are fixed here so that every file agrees on the feedback word formats.
package transmit_delay_scheduler_pkg;

    localparam int DW_N_INTEGER     = 13;
    localparam int DW_ERROR_INTEGER = 14;
    localparam int DW_FRACTION      = 4;

    localparam int N_W   = DW_N_INTEGER + DW_FRACTION + 1;
    localparam int ERR_W = DW_ERROR_INTEGER + DW_FRACTION + 1;

    typedef logic        [N_W-1:0]          n_t;
    typedef logic signed [ERR_W-1:0]        err_t;
    typedef logic        [DW_N_INTEGER-1:0] delay_int_t;

    localparam delay_int_t DELAY_MAX = {DW_N_INTEGER{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_READY = 2'd1,
        S_FIRE       = 2'd2,
        S_DONE       = 2'd3
    } sched_state_t;

endpackage

// File: rtl/transmit_delay_scheduler_delay_round_sat.sv
// Rounds one fixed-point delay to whole clock cycles (half rounds up) and
// clamps to the largest value the cycle counter can reach.
module delay_round_sat
    import transmit_delay_scheduler_pkg::*;
(
    input  n_t         n_i,
    output delay_int_t delay_o
);

    localparam int SUM_W   = N_W + 1;
    localparam int WHOLE_W = SUM_W - DW_FRACTION;
    localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(2 ** (DW_FRACTION - 1));

    logic [SUM_W-1:0]   sum_s;
    logic [WHOLE_W-1:0] whole_s;

    // Add half an LSB, drop the fraction, clamp anything above the counter range
    always_comb begin
        sum_s   = {1'b0, n_i} + ROUND_BIAS;
        whole_s = sum_s[SUM_W-1:DW_FRACTION];
        if (|whole_s[WHOLE_W-1:DW_N_INTEGER]) begin
            delay_o = DELAY_MAX;
        end else begin
            delay_o = whole_s[DW_N_INTEGER-1:0];
        end
    end

endmodule

// File: rtl/transmit_delay_scheduler.sv
// Accepts each scanpoint result from the increment-and-compare array, keeps the
// feedback delay/error state, and fires one transmit pulse per element at its rounded delay.
module transmit_delay_scheduler
    import transmit_delay_scheduler_pkg::*;
#(
    parameter int NUM_ELEMENTS   = 64,
    parameter int NUM_SCANPOINTS = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  n_t                      n_init     [NUM_ELEMENTS],
    input  n_t                      n_in       [NUM_ELEMENTS],
    input  err_t                    error_in   [NUM_ELEMENTS],
    input  logic                    calc_ready,
    output logic                    ack,
    output n_t                      n_prev     [NUM_ELEMENTS],
    output err_t                    error_prev [NUM_ELEMENTS],
    output logic [NUM_ELEMENTS-1:0] tx_fire,
    output logic                    transmit_done,
    output logic                    final_scanpoint,
    output logic                    busy
);

    localparam int SP_W = (NUM_SCANPOINTS > 1) ? $clog2(NUM_SCANPOINTS) : 1;
    localparam logic [SP_W-1:0] SP_LAST = SP_W'(NUM_SCANPOINTS - 1);
    localparam logic [SP_W-1:0] SP_STEP = SP_W'(1);
    localparam delay_int_t      CNT_STEP = delay_int_t'(1);

    sched_state_t            state_q, state_d;
    n_t                      n_prev_q   [NUM_ELEMENTS];
    n_t                      n_prev_d   [NUM_ELEMENTS];
    err_t                    err_prev_q [NUM_ELEMENTS];
    err_t                    err_prev_d [NUM_ELEMENTS];
    delay_int_t              delay_q    [NUM_ELEMENTS];
    delay_int_t              delay_d    [NUM_ELEMENTS];
    delay_int_t              rounded_s  [NUM_ELEMENTS];
    logic [NUM_ELEMENTS-1:0] fired_q, fired_d;
    logic [NUM_ELEMENTS-1:0] tx_fire_q, tx_fire_d;
    delay_int_t              cnt_q, cnt_d;
    logic [SP_W-1:0]         sp_q, sp_d;
    logic                    ack_q, ack_d;
    logic                    done_q, done_d;
    logic                    final_q, final_d;
    logic                    busy_q, busy_d;

    for (genvar g = 0; g < NUM_ELEMENTS; g++) begin : g_round
        delay_round_sat u_round (
            .n_i     (n_in[g]),
            .delay_o (rounded_s[g])
        );
    end

    // Next-state and next-output logic; abort overrides every state
    always_comb begin
        state_d    = state_q;
        n_prev_d   = n_prev_q;
        err_prev_d = err_prev_q;
        delay_d    = delay_q;
        fired_d    = fired_q;
        cnt_d      = cnt_q;
        sp_d       = sp_q;
        ack_d      = 1'b0;
        tx_fire_d  = '0;
        done_d     = 1'b0;
        final_d    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        n_prev_d = n_init;
                        for (int i = 0; i < NUM_ELEMENTS; i++) begin
                            err_prev_d[i] = '0;
                        end
                        sp_d    = '0;
                        state_d = S_WAIT_READY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT_READY: begin
                    if (calc_ready) begin
                        n_prev_d   = n_in;
                        err_prev_d = error_in;
                        delay_d    = rounded_s;
                        fired_d    = '0;
                        cnt_d      = '0;
                        ack_d      = 1'b1;
                        state_d    = S_FIRE;
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end
                S_FIRE: begin
                    for (int i = 0; i < NUM_ELEMENTS; i++) begin
                        tx_fire_d[i] = (cnt_q == delay_q[i]) && !fired_q[i];
                    end
                    fired_d = fired_q | tx_fire_d;
                    cnt_d   = cnt_q + CNT_STEP;
                    if (&fired_d) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FIRE;
                    end
                end
                S_DONE: begin
                    done_d = 1'b1;
                    sp_d   = sp_q + SP_STEP;
                    if (sp_q == SP_LAST) begin
                        final_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT_READY;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, feedback and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < NUM_ELEMENTS; i++) begin
                n_prev_q[i]   <= '0;
                err_prev_q[i] <= '0;
                delay_q[i]    <= '0;
            end
            fired_q   <= '0;
            tx_fire_q <= '0;
            cnt_q     <= '0;
            sp_q      <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            final_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_prev_q   <= n_prev_d;
            err_prev_q <= err_prev_d;
            delay_q    <= delay_d;
            fired_q    <= fired_d;
            tx_fire_q  <= tx_fire_d;
            cnt_q      <= cnt_d;
            sp_q       <= sp_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            final_q    <= final_d;
            busy_q     <= busy_d;
        end
    end

    assign ack             = ack_q;
    assign n_prev          = n_prev_q;
    assign error_prev      = err_prev_q;
    assign tx_fire         = tx_fire_q;
    assign transmit_done   = done_q;
    assign final_scanpoint = final_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_transmit_delay_scheduler.sv
// Self-checking bench: two schedulers (3 and 1 scanpoints per line) share stimulus;
// fire times come from a rounding model and a table of hand-computed vectors.
module tb_transmit_delay_scheduler;
    import transmit_delay_scheduler_pkg::*;

    localparam int E = 4;

    typedef struct packed {
        logic [E-1:0][N_W-1:0] n;
        logic [E-1:0][15:0]    cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic calc_ready = 1'b0;
    n_t   n_init_s [E];
    n_t   n_in_s   [E];
    err_t err_in_s [E];

    logic         ack_a, done_a, final_a, busy_a;
    logic [E-1:0] tx_a;
    n_t           n_prev_a [E];
    err_t         err_prev_a [E];
    logic         ack_b, done_b, final_b, busy_b;
    logic [E-1:0] tx_b;
    n_t           n_prev_b [E];
    err_t         err_prev_b [E];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   ack_cnt;
    n_t   cur_n   [E];
    err_t cur_e   [E];
    int   cur_exp [E];
    vec_t tbl [3];

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack_a) ack_cnt <= ack_cnt + 1;
    end

    transmit_delay_scheduler #(.NUM_ELEMENTS(E), .NUM_SCANPOINTS(3)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_init(n_init_s), .n_in(n_in_s), .error_in(err_in_s), .calc_ready(calc_ready),
        .ack(ack_a), .n_prev(n_prev_a), .error_prev(err_prev_a), .tx_fire(tx_a),
        .transmit_done(done_a), .final_scanpoint(final_a), .busy(busy_a)
    );

    transmit_delay_scheduler #(.NUM_ELEMENTS(E), .NUM_SCANPOINTS(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_init(n_init_s), .n_in(n_in_s), .error_in(err_in_s), .calc_ready(calc_ready),
        .ack(ack_b), .n_prev(n_prev_b), .error_prev(err_prev_b), .tx_fire(tx_b),
        .transmit_done(done_b), .final_scanpoint(final_b), .busy(busy_b)
    );

    // Delay in cycles: n/16 rounded half-up, limited to 2^13-1
    function automatic int model_cycles(input n_t n);
        int r;
        r = (int'(n) + 8) / 16;
        if (r > 8191) r = 8191;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy_a), 64'(1));
        for (int i = 0; i < E; i++) begin
            check("n_prev_init", 64'(n_prev_a[i]), 64'(n_init_s[i]));
            check("error_prev_init", 64'(err_prev_a[i]), 64'(0));
        end
    endtask

    // One scanpoint: present cur_n/cur_e, expect ack, fires at cur_exp, then done
    task automatic run_sp(input logic exp_final, input logic hold, input logic chk_b);
        int last;
        logic [E-1:0] mask;
        for (int i = 0; i < E; i++) begin
            n_in_s[i]   = cur_n[i];
            err_in_s[i] = cur_e[i];
        end
        calc_ready = 1'b1;
        @(posedge clk); #1;
        check("ack", 64'(ack_a), 64'(1));
        if (chk_b) check("ack_s1", 64'(ack_b), 64'(1));
        for (int i = 0; i < E; i++) begin
            check("n_prev", 64'(n_prev_a[i]), 64'(cur_n[i]));
            check("error_prev", 64'(err_prev_a[i]), 64'(cur_e[i]));
        end
        if (!hold) calc_ready = 1'b0;
        last = 0;
        for (int i = 0; i < E; i++) if (cur_exp[i] > last) last = cur_exp[i];
        for (int c = 0; c <= last; c++) begin
            @(posedge clk); #1;
            mask = '0;
            for (int i = 0; i < E; i++) mask[i] = (cur_exp[i] == c);
            check("tx_fire", 64'(tx_a), 64'(mask));
            check("ack_single", 64'(ack_a), 64'(0));
            check("done_early", 64'(done_a), 64'(0));
            if (chk_b) check("tx_fire_s1", 64'(tx_b), 64'(mask));
        end
        @(posedge clk); #1;
        check("transmit_done", 64'(done_a), 64'(1));
        check("final_scanpoint", 64'(final_a), 64'(exp_final));
        check("tx_after_done", 64'(tx_a), 64'(0));
        if (chk_b) begin
            check("done_s1", 64'(done_b), 64'(1));
            check("final_s1", 64'(final_b), 64'(1));
        end
    endtask

    task automatic random_line();
        for (int sp = 0; sp < 3; sp++) begin
            for (int i = 0; i < E; i++) begin
                cur_n[i]   = n_t'($urandom_range(0, 255));
                cur_e[i]   = err_t'($urandom);
                cur_exp[i] = model_cycles(cur_n[i]);
            end
            run_sp(sp == 2, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int base;
        tbl[0].n   = {18'h00007, 18'h00020, 18'h00018, 18'h00000};
        tbl[0].cyc = {16'd0, 16'd2, 16'd2, 16'd0};
        tbl[1].n   = {18'h00010, 18'h00050, 18'h00017, 18'h00008};
        tbl[1].cyc = {16'd1, 16'd5, 16'd1, 16'd1};
        tbl[2].n   = {18'h00028, 18'h1FFF7, 18'h1FFF8, 18'h3FFFF};
        tbl[2].cyc = {16'd3, 16'd8191, 16'd8191, 16'd8191};

        for (int i = 0; i < E; i++) begin
            n_init_s[i] = n_t'($urandom);
            n_in_s[i]   = '0;
            err_in_s[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy_a), 64'(0));
        check("reset_ack", 64'(ack_a), 64'(0));
        check("reset_n_prev", 64'(n_prev_a[0]), 64'(0));
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", 64'(busy_a), 64'(0));

        // Hand-computed vectors; first one also ends the single-scanpoint line
        do_start();
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < E; i++) begin
                cur_n[i]   = tbl[v].n[i];
                cur_e[i]   = err_t'($urandom);
                cur_exp[i] = int'(tbl[v].cyc[i]);
            end
            run_sp(v == 2, 1'b0, v == 0);
        end
        check("idle_after_line", 64'(busy_a), 64'(0));
        check("idle_s1", 64'(busy_b), 64'(0));

        // calc_ready held high across a whole line: one ack per scanpoint
        do_start();
        base = ack_cnt;
        for (int sp = 0; sp < 3; sp++) begin
            for (int i = 0; i < E; i++) begin
                cur_n[i]   = n_t'($urandom_range(0, 40));
                cur_e[i]   = (i == 0) ? -err_t'(5) : err_t'($urandom);
                cur_exp[i] = model_cycles(cur_n[i]);
            end
            run_sp(sp == 2, 1'b1, 1'b0);
        end
        repeat (6) @(posedge clk);
        #1;
        calc_ready = 1'b0;
        check("ack_count_held", 64'(ack_cnt - base), 64'(3));
        check("idle_after_held", 64'(busy_a), 64'(0));

        // Randomized lines against the rounding model
        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < E; i++) n_init_s[i] = n_t'($urandom);
            do_start();
            random_line();
        end

        // Abort on FIRE cycle 1 with all delays at 3
        do_start();
        for (int i = 0; i < E; i++) n_in_s[i] = 18'h00030;
        calc_ready = 1'b1;
        @(posedge clk); #1;
        calc_ready = 1'b0;
        check("abort_ack", 64'(ack_a), 64'(1));
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_busy", 64'(busy_a), 64'(0));
        for (int c = 0; c < 6; c++) begin
            check("abort_no_fire", 64'(tx_a), 64'(0));
            @(posedge clk); #1;
        end
        check("abort_keeps_n_prev", 64'(n_prev_a[2]), 64'(18'h00030));

        // abort wins over start in the same cycle
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", 64'(busy_a), 64'(0));

        // Restart after abort counts scanpoints from zero
        do_start();
        random_line();

        // Asynchronous reset in the middle of FIRE
        do_start();
        for (int i = 0; i < E; i++) n_in_s[i] = 18'h00050;
        calc_ready = 1'b1;
        @(posedge clk); #1;
        calc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy_a), 64'(0));
        check("rst_tx", 64'(tx_a), 64'(0));
        check("rst_n_prev", 64'(n_prev_a[1]), 64'(0));
        check("rst_err_prev", 64'(err_prev_a[1]), 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("post_rst_no_fire", 64'(tx_a), 64'(0));
            check("post_rst_idle", 64'(busy_a), 64'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
